// File: rtl/wave_ram_loader.sv
// wave_ram_loader
//   Write-side feeder for the waveform lookup RAM. Accepts a valid/ready
//   sample stream and writes the samples to consecutive RAM addresses
//   starting at a base address. The address wraps at the top of the table.
//   done pulses only after the last write has been on the RAM port.
// Ports
//   i_clk, i_rst_n           clock, async active-low reset
//   i_start                  1-cycle load request (only seen in IDLE)
//   i_base_addr, i_length    load parameters, captured on an accepted start
//   i_abort                  cancel a load in progress
//   i_s_valid, i_s_data      sample stream in
//   o_s_ready                sample accepted this cycle when valid
//   o_wr_en/addr/data        registered RAM write port
//   o_busy, o_done, o_count  status
module wave_ram_loader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [ADDRESS_WIDTH:0]   i_length,
  input  logic                     i_abort,
  input  logic                     i_s_valid,
  input  logic [DATA_WIDTH-1:0]    i_s_data,
  output logic                     o_s_ready,
  output logic                     o_wr_en,
  output logic [ADDRESS_WIDTH-1:0] o_wr_addr,
  output logic [DATA_WIDTH-1:0]    o_wr_data,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDRESS_WIDTH:0]   o_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic [ADDRESS_WIDTH-1:0] r_ptr;
  logic [ADDRESS_WIDTH:0]   r_rem;
  logic [ADDRESS_WIDTH:0]   r_count;
  logic                     r_wr_en;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]    r_wr_data;
  logic                     w_beat;
  logic                     w_accept;

  // abort wins over a handshake in the same cycle: the sample is dropped
  assign w_beat   = (r_state == S_LOAD) && i_s_valid && !i_abort;
  assign w_accept = (r_state == S_IDLE) && i_start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (i_length != '0) ? S_LOAD : S_DONE;
      S_LOAD: begin
        if (i_abort)                            w_next = S_IDLE;
        else if (w_beat && r_rem == 1)          w_next = S_FLUSH;
      end
      // one cycle to let the last registered write reach the port
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr     <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_beat;
      if (w_accept) begin
        r_ptr   <= i_base_addr;
        r_rem   <= i_length;
        r_count <= '0;
      end
      if (w_beat) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= i_s_data;
        r_ptr     <= r_ptr + 1'b1;   // natural wrap modulo table depth
        r_count   <= r_count + 1'b1;
        r_rem     <= r_rem - 1'b1;
      end
    end
  end

  assign o_s_ready = (r_state == S_LOAD);
  assign o_busy    = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_count   = r_count;

endmodule

// File: tb/tb_wave_ram_loader.sv
module tb_wave_ram_loader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 0, rst_n = 0;
  logic          start = 0, abort = 0, s_valid = 0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready, wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   count;

  int vec = 0, miscmp = 0;
  int done_cnt = 0;
  logic [AW-1:0] got_a[$], exp_a[$];
  logic [DW-1:0] got_d[$], exp_d[$];

  wave_ram_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_length(length), .i_abort(abort), .i_s_valid(s_valid), .i_s_data(s_data),
    .o_s_ready(s_ready), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_count(count));

  always #5 clk = ~clk;

  // write/done monitor: records what the RAM port sees each cycle
  always @(posedge clk) begin
    #1;
    if (wr_en) begin got_a.push_back(wr_addr); got_d.push_back(wr_data); end
    if (done) done_cnt++;
  end

  task automatic check_outputs_zero(input string nm);
    vec++; if ({s_ready, wr_en, busy, done} !== 4'b0) begin miscmp++;
      $display("FAIL %s flags got %b want 0000", nm, {s_ready, wr_en, busy, done}); end
    vec++; if ({wr_addr, wr_data, count} !== '0) begin miscmp++;
      $display("FAIL %s addr/data/count got %h/%h/%0d want 0", nm, wr_addr, wr_data, count); end
  endtask

  // Drives one load and checks it against the reference: accepted beat i
  // goes to address (base+i) mod 2**AW with the data offered on that beat.
  task automatic run_load(input logic [AW-1:0] base, input int len, input int use_pat,
                          input logic [31:0] pat, input int abort_after, input int mid_start,
                          input string nm);
    int k = 0, cyc = 0;
    bit aborted = 0;
    logic v;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    exp_a.delete(); exp_d.delete();
    @(negedge clk);
    got_a.delete(); got_d.delete(); done_cnt = 0;
    start = 1; base_addr = base; length = len[AW:0];
    @(negedge clk);
    start = 0; base_addr = ~base; length = 9'd7;
    if (len == 0) begin
      vec++; if ({done, busy, wr_en} !== 3'b110) begin miscmp++;
        $display("FAIL %s zero-len done/busy/wr_en got %b want 110", nm, {done, busy, wr_en}); end
      @(negedge clk);
    end else begin
      while (k < len && !aborted) begin
        vec++; if (s_ready !== 1'b1) begin miscmp++;
          $display("FAIL %s s_ready cyc %0d got %b want 1", nm, cyc, s_ready); end
        if (cyc > 4000) begin vec++; miscmp++;
          $display("FAIL %s timeout got %0d beats want %0d", nm, k, len); break; end
        v = use_pat ? pat[cyc % 32] : ($urandom_range(0, 99) < 60);
        d = DW'($urandom);
        s_valid = v; s_data = d;
        start = (mid_start != 0 && cyc == 1);
        if (abort_after >= 0 && k == abort_after) begin
          abort = 1; s_valid = 1; aborted = 1;
        end else if (v) begin
          a = base + k[AW-1:0];
          exp_a.push_back(a); exp_d.push_back(d); k++;
        end
        cyc++;
        @(negedge clk);
        abort = 0; s_valid = 0; start = 0;
      end
      if (aborted) begin
        vec++; if ({busy, s_ready} !== 2'b00) begin miscmp++;
          $display("FAIL %s after abort busy/ready got %b want 00", nm, {busy, s_ready}); end
      end else begin
        vec++; if ({s_ready, busy, done, wr_en} !== 4'b0101) begin miscmp++;
          $display("FAIL %s flush ready/busy/done/wr_en got %b want 0101", nm, {s_ready, busy, done, wr_en}); end
        @(negedge clk);
        vec++; if ({done, busy, wr_en} !== 3'b110) begin miscmp++;
          $display("FAIL %s done cycle done/busy/wr_en got %b want 110", nm, {done, busy, wr_en}); end
        @(negedge clk);
      end
    end
    vec++; if ({done, busy} !== 2'b00) begin miscmp++;
      $display("FAIL %s idle done/busy got %b want 00", nm, {done, busy}); end
    repeat (3) @(negedge clk);
    vec++; if (count !== k[AW:0]) begin miscmp++;
      $display("FAIL %s count got %0d want %0d", nm, count, k); end
    vec++; if (done_cnt !== (aborted ? 0 : 1)) begin miscmp++;
      $display("FAIL %s done pulses got %0d want %0d", nm, done_cnt, aborted ? 0 : 1); end
    vec++;
    if (got_a.size() != exp_a.size()) begin miscmp++;
      $display("FAIL %s write count got %0d want %0d", nm, got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < exp_a.size(); i++) begin
        vec++; if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin miscmp++;
          $display("FAIL %s write %0d got %h:%h want %h:%h", nm, i, got_a[i], got_d[i], exp_a[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0; #2;
    check_outputs_zero("reset");
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    check_outputs_zero("post_reset");
  endtask

  task automatic test_basic;       run_load(8'h10, 4, 1, 32'hFFFF_FFFF, -1, 0, "basic"); endtask
  task automatic test_wrap;        run_load(8'hFE, 4, 0, 32'h0, -1, 0, "wrap"); endtask
  task automatic test_stall;       run_load(8'h40, 3, 1, 32'b101001, -1, 0, "stall"); endtask
  task automatic test_zero_len;    run_load(8'h22, 0, 0, 32'h0, -1, 0, "zero_len"); endtask
  task automatic test_start_in_load; run_load(8'h80, 5, 1, 32'b11111100, -1, 1, "start_in_load"); endtask
  task automatic test_abort;       run_load(8'h30, 5, 1, 32'hFFFF_FFFF, 2, 0, "abort"); endtask
  task automatic test_full_wrap;   run_load(8'h37, 256, 0, 32'h0, -1, 0, "full_wrap"); endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++)
      run_load(AW'($urandom), $urandom_range(1, 20), 0, 32'h0,
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1, 0, "random");
  endtask

  task automatic test_reset_midload;
    @(negedge clk);
    done_cnt = 0;
    start = 1; base_addr = 8'h55; length = 9'd6;
    @(negedge clk); start = 0;
    s_valid = 1; s_data = 8'hA5;
    repeat (2) @(negedge clk);
    rst_n = 0; #1;
    check_outputs_zero("reset_midload");
    @(negedge clk); rst_n = 1; s_valid = 0;
    repeat (2) @(negedge clk);
    vec++; if ({busy, s_ready, done_cnt != 0} !== 3'b000) begin miscmp++;
      $display("FAIL reset_midload busy/ready/done_seen got %b want 000", {busy, s_ready, done_cnt != 0}); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_zero_len;
    test_start_in_load;
    test_abort;
    test_full_wrap;
    test_random;
    test_reset_midload;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
